// File: rtl/mbledhesi_pkg.sv
// Shared definitions for the sequential adder/subtractor (mbledhesi_sekuencial):
// FSM state encoding, default geometry and the counter-sizing helper.
package mbledhesi_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count n slices. Never returns less than 1, so that
  // N=1 still gets a real register.
  function automatic int clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mbledhesi_sekuencial_if.sv
// Handshake and operand/result bundle for mbledhesi_sekuencial.
// master = requester (drives start/operands), slave = the adder itself.
interface mbledhesi_sekuencial_if
  import mbledhesi_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, sub, cin,
    input  busy, done, result, cout, overflow, zero
  );

  modport slave (
    input  start, a, b, sub, cin,
    output busy, done, result, cout, overflow, zero
  );

endinterface

// File: rtl/mbledhesi_sekuencial_shuma_pjese.sv
// shuma_pjese: combinational CHUNK-bit ripple of full-adder cells.
// Besides the sum and carry out it exposes the carry into the top bit,
// which the parent needs for the signed-overflow flag.
module shuma_pjese
  import mbledhesi_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  // Ripple through the full-adder cells, LSB first.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path can leave it unassigned and infer a latch.
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/mbledhesi_sekuencial.sv
// mbledhesi_sekuencial: multi-cycle adder/subtractor. Adds one CHUNK-bit
// slice per clock, LSB first, with the inter-slice carry held in a register.
// Handshake: start (accepted in IDLE or DONE), busy, one-cycle done.
// Optional build macro MBLEDHESI_SAT_EN: saturate the result on signed
// overflow (cout/overflow still report the raw condition).
module mbledhesi_sekuencial
  import mbledhesi_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mbledhesi_sekuencial_if.slave   bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = clog2(N);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  // A width that is not a whole number of slices would leave a ragged top
  // slice; refuse to build it at all.
  if (WIDTH % CHUNK != 0) begin : g_bad_geometry
    $fatal(1, "mbledhesi_sekuencial: WIDTH (%0d) must be a multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;       // already inverted for subtraction
  logic             carry_q;   // carry into the current slice
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  int               shift;
  logic [CHUNK-1:0] sl_a;
  logic [CHUNK-1:0] sl_b;
  logic [CHUNK-1:0] sl_sum;
  logic             sl_cout;
  logic             sl_cmsb;
  logic             last;
  logic             ovf_next;
  logic [WIDTH-1:0] res_next;
  logic             accept;

  // Single shared slice adder; the counter selects which slice feeds it.
  shuma_pjese #(
    .CHUNK (CHUNK)
  ) u_shuma (
    .a        (sl_a),
    .b        (sl_b),
    .cin      (carry_q),
    .sum      (sl_sum),
    .cout     (sl_cout),
    .c_msb_in (sl_cmsb)
  );

  // Slice selection, merge of the new slice into the result and final flags.
  always_comb begin
    shift    = int'(cnt_q) * CHUNK;
    sl_a     = CHUNK'(a_q >> shift);
    sl_b     = CHUNK'(b_q >> shift);
    last     = (cnt_q == CNT_W'(N - 1));
    ovf_next = sl_cmsb ^ sl_cout;
    res_next = (result_q & ~(SLICE_MASK << shift)) | (WIDTH'(sl_sum) << shift);
`ifdef MBLEDHESI_SAT_EN
    // Overflow means both effective operands share a sign, so A's MSB
    // tells which rail to clamp to.
    if (last && ovf_next) begin
      res_next = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);

  // FSM, operand capture, slice accumulation and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_q      <= bus.a;
            b_q      <= bus.b ^ {WIDTH{bus.sub}};
            carry_q  <= bus.cin ^ bus.sub;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          result_q <= res_next;
          carry_q  <= sl_cout;
          cnt_q    <= cnt_q + 1'b1;
          if (last) begin
            cout_q  <= sl_cout;
            ovf_q   <= ovf_next;
            zero_q  <= (res_next == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_mbledhesi_sekuencial.sv
// Directed self-checking bench for mbledhesi_sekuencial (WIDTH=16, CHUNK=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_mbledhesi_sekuencial;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

`ifdef MBLEDHESI_SAT_EN
  localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_OVF = 16'h8000;
  localparam logic [15:0] EXP_NEG_OVF = 16'h7FFF;
`endif

  mbledhesi_sekuencial_if #(.WIDTH(16)) bus ();

  mbledhesi_sekuencial #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) for done; lat counts falling edges after the accept
  // edge's falling edge, bcnt counts those where busy was high.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", bus.done, lat);
    end
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tsub, input logic tcin,
                        output logic [15:0] r, output logic [2:0] flags,
                        output int lat, output int bcnt);
    @(negedge clk);
    bus.a     = ta;
    bus.b     = tb_v;
    bus.sub   = tsub;
    bus.cin   = tcin;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    r     = bus.result;
    flags = {bus.cout, bus.overflow, bus.zero};
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.result, bus.busy, bus.done, bus.cout, bus.overflow, bus.zero} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs: result=%h busy=%b done=%b c/v/z=%b%b%b, required all 0",
               bus.result, bus.busy, bus.done, bus.cout, bus.overflow, bus.zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_basic();
    logic [15:0] r;
    logic [2:0]  f;
    int          lat, bcnt;
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, r, f, lat, bcnt);
    checks++;
    if (r !== 16'h2233) begin
      failures++;
      $display("FAIL add_basic_result: got %h, required 2233", r);
    end
    checks++;
    if (f !== 3'b000) begin
      failures++;
      $display("FAIL add_basic_flags: c/v/z got %b, required 000", f);
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL add_basic_latency: got %0d, required 4", lat);
    end
    checks++;
    if (bcnt !== 4) begin
      failures++;
      $display("FAIL add_basic_busy_cycles: got %0d, required 4", bcnt);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 16'h2233) begin
      failures++;
      $display("FAIL add_basic_hold: done=%b busy=%b result=%h, required 0 0 2233",
               bus.done, bus.busy, bus.result);
    end
  endtask

  task automatic test_add_wrap();
    logic [15:0] r;
    logic [2:0]  f;
    int          lat, bcnt;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, r, f, lat, bcnt);
    checks++;
    if (r !== 16'h0000 || f !== 3'b101) begin
      failures++;
      $display("FAIL add_wrap: result=%h c/v/z=%b, required 0000 101", r, f);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] r;
    logic [2:0]  f;
    int          lat, bcnt;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, r, f, lat, bcnt);
    checks++;
    if (r !== EXP_POS_OVF || f !== 3'b010) begin
      failures++;
      $display("FAIL add_pos_overflow: result=%h c/v/z=%b, required %h 010", r, f, EXP_POS_OVF);
    end
    // 0x8000 + 0xFFFE + 1 = 0x17FFF: carry out set, no borrow.
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, r, f, lat, bcnt);
    checks++;
    if (r !== EXP_NEG_OVF || f !== 3'b110) begin
      failures++;
      $display("FAIL sub_neg_overflow: result=%h c/v/z=%b, required %h 110", r, f, EXP_NEG_OVF);
    end
  endtask

  task automatic test_sub_borrow();
    logic [15:0] r;
    logic [2:0]  f;
    int          lat, bcnt;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, r, f, lat, bcnt);
    checks++;
    if (r !== 16'hFFFE || f !== 3'b000) begin
      failures++;
      $display("FAIL sub_borrow: result=%h c/v/z=%b, required FFFE 000", r, f);
    end
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, r, f, lat, bcnt);
    checks++;
    if (r !== 16'hFFFD || f !== 3'b000) begin
      failures++;
      $display("FAIL sub_borrow_in: result=%h c/v/z=%b, required FFFD 000", r, f);
    end
  endtask

  task automatic test_start_ignored();
    int lat, bcnt;
    @(negedge clk);
    bus.a     = 16'h0100;
    bus.b     = 16'h0023;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    // Accepted; keep start high over RUN edges 1 and 2 with different operands.
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    bus.sub = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    checks++;
    if (lat !== 2 || bus.result !== 16'h0123 || bus.cout !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored: lat=%0d result=%h cout=%b, required 2 0123 0",
               lat, bus.result, bus.cout);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    logic [2:0]  f;
    int          lat, bcnt;
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, r, f, lat, bcnt);
    checks++;
    if (r !== 16'h0003) begin
      failures++;
      $display("FAIL b2b_first: got %h, required 0003", r);
    end
    // Still in the DONE cycle: present the next request now.
    bus.a     = 16'h1111;
    bus.b     = 16'h0111;
    bus.sub   = 1'b1;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.result !== 16'h0000) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b done=%b result=%h, required 1 0 0000",
               bus.busy, bus.done, bus.result);
    end
    wait_done(lat, bcnt);
    checks++;
    if (lat !== 4 || bus.result !== 16'h1000 || bus.cout !== 1'b1 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d result=%h cout=%b ovf=%b, required 4 1000 1 0",
               lat, bus.result, bus.cout, bus.overflow);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    logic [2:0]  f;
    int          lat, bcnt;
    int          seen;
    @(negedge clk);
    bus.a     = 16'h1234;
    bus.b     = 16'h0FFF;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.result, bus.busy, bus.done, bus.cout, bus.overflow, bus.zero} !== 21'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: result=%h busy=%b done=%b c/v/z=%b%b%b, required all 0",
               bus.result, bus.busy, bus.done, bus.cout, bus.overflow, bus.zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: %0d cycles with done/busy, required 0", seen);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, r, f, lat, bcnt);
    checks++;
    if (r !== 16'h0100 || f !== 3'b000 || lat !== 4) begin
      failures++;
      $display("FAIL reset_mid_recover: result=%h c/v/z=%b lat=%0d, required 0100 000 4",
               r, f, lat);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add_basic();
    test_add_wrap();
    test_overflow();
    test_sub_borrow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
